cpu_ctrl_fsm: RTL and testbench
===============================

// Module: cpu_ctrl_fsm
// PURPOSE
//   Multi-cycle control unit: fetches 16-bit instructions, decodes the shared cpu/alu/load encodings and
//   sequences ALU, register file and data memory for one instruction at a time. Sits between instruction
//   memory, data memory and the datapath (RF, ALU, writeback mux); owns the PC.
// PARAMETERS
//   PC_W      8     PC / instruction address width
//   RESET_PC  0     PC value loaded on reset
// PORTS
//   clk          in   1     single clock, rising edge
//   rst          in   1     synchronous, active-high reset
//   run          in   1     1 = fetch new instructions; 0 = finish current instruction, then idle in FETCH
//   imem_req     out  1     instruction fetch request, held until imem_ack
//   imem_addr    out  PC_W  fetch address (= PC)
//   imem_ack     in   1     fetch done; imem_rdata valid this cycle
//   imem_rdata   in   16    instruction word
//   dmem_req     out  1     data memory request, held until dmem_ack
//   dmem_we      out  1     1 = write (STOREMEM), 0 = read (LOAD MEM)
//   dmem_ack     in   1     data access done
//   alu_op       out  3     alu_instructions code to ALU
//   alu_en       out  1     one-cycle ALU strobe (EXEC state)
//   rf_raddr_a   out  4     RF read port A = IR[7:4]
//   rf_raddr_b   out  4     RF read port B = IR[3:0]
//   rf_waddr     out  4     RF write address = IR[11:8]
//   rf_we        out  1     one-cycle RF write strobe (WB state)
//   wb_sel       out  2     load_type driving the writeback mux
//   imm          out  6     immediate IR[5:0], zero-extended by datapath
//   pc           out  PC_W  current PC
//   busy         out  1     high in any state except idle FETCH (run=0, no request pending)
//   illegal      out  1     one-cycle pulse on illegal opcode (ILLEGAL_TRAP_EN only; else tied 0)
// BEHAVIOUR
//   Format: [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2; LOAD: [7:6] load_type, [5:0] imm; JUMP: target=IR[PC_W-1:0].
//   Ops: 0000-0110 ALU (alu_op=op[2:0]); 0111 LOAD (alu_op=LOAD_OP); 1000 STOREMEM; 1001 STORERF; 1010 JUMP;
//   1111 NOP; 1011-1110 illegal.
//   States: FETCH -> DECODE -> {EXEC, MEM, WB, FETCH}; EXEC -> WB; MEM -> {WB, FETCH}; WB -> FETCH; HALT (trap only).
//   FETCH: imem_req=run; on imem_req&imem_ack latch IR, go DECODE. run=0 while req held: req still held to ack.
//   DECODE (1 cycle): ALU op -> EXEC; LOAD RF/DEFAULT -> EXEC; LOAD MEM -> MEM; LOAD IMM -> WB; STOREMEM -> MEM;
//     STORERF -> WB; JUMP -> FETCH with pc<=target; NOP -> FETCH with pc<=pc+1.
//   EXEC (1 cycle): alu_en=1, alu_op valid -> WB.
//   MEM: dmem_req=1, dmem_we=(op==STOREMEM) until dmem_ack; LOAD -> WB; STOREMEM -> FETCH, pc<=pc+1.
//   WB (1 cycle): rf_we=1; pc<=pc+1 -> FETCH. wb_sel: ALU ops -> RF_load(00); LOAD -> IR[7:6] (DEFAULT=11 treated as RF);
//     STORERF -> RF_load.
//   Latency with zero-wait memories (ack same cycle as req): ALU/LOAD-RF 4 cycles, LOAD-IMM 3, LOAD-MEM 4,
//     STOREMEM 3, STORERF 3, JUMP/NOP 2.
//   PC arithmetic mod 2^PC_W: 2^PC_W-1 + 1 wraps to 0. Jump target truncated to PC_W.
//   acks ignored when matching req is low; simultaneous imem_ack and dmem_ack only the one for current state counts.
//   Reset values: state=FETCH, pc=RESET_PC, IR=16'hF000 (NOP), all strobes/reqs/illegal/busy=0, alu_op=0, wb_sel=0.
//   Reset mid-transaction: outstanding req dropped next cycle; no RF write; PC reloaded.
//   rf_raddr_*, rf_waddr, imm, alu_op combinational from IR; valid from DECODE through WB.
// CONFIGURATION
//   ILLEGAL_TRAP_EN defined: illegal opcode in DECODE pulses illegal for 1 cycle, enters HALT (no reqs,
//     busy=1, pc frozen); only rst exits HALT.
//   ILLEGAL_TRAP_EN undefined: illegal opcodes executed as NOP (pc+1), illegal tied 0, HALT unreachable.
// TESTING
//   ALU: reset, run=1, imem returns 16'h1321 (SUBTRACT) zero-wait -> alu_en cycle 3, alu_op=001, rf_we cycle 4,
//     rf_waddr=3, pc 0->1.
//   LOAD MEM: 16'h7540 with dmem_ack after 3 wait cycles -> dmem_req held 4 cycles, dmem_we=0, rf_we with wb_sel=01.
//   LOAD IMM / STOREMEM: 16'h75AA -> no alu_en, rf_we wb_sel=10 imm=6'h2A; 16'h8210 -> dmem_we=1, no rf_we, pc+1.
//   JUMP/wrap: 16'hA0FF at pc=0 -> pc=8'hFF; NOP at pc=8'hFF -> pc=8'h00.
//   run/reset: run=0 -> imem_req=0, busy=0 after current instr; rst during MEM wait -> dmem_req=0 next cycle,
//     pc=RESET_PC, no rf_we.
//   Illegal 16'hB000: with ILLEGAL_TRAP_EN -> illegal pulse, HALT, no imem_req; without -> pc+1, illegal=0.

Source files
------------

// File: rtl/cpu_ctrl_fsm_if.sv
// ----------------------------------------------------------------------------
// cpu_ctrl_fsm_if
//   Bundles the control unit's memory handshakes and datapath control lines.
//   master : the control unit (drives requests and datapath controls)
//   slave  : memories/datapath (drive acks and instruction data)
// Signals
//   imem_req/imem_addr/imem_ack/imem_rdata : instruction fetch handshake
//   dmem_req/dmem_we/dmem_ack              : data memory handshake
//   alu_op/alu_en                          : ALU operation and strobe
//   rf_raddr_a/rf_raddr_b/rf_waddr/rf_we   : register file addressing and write
//   wb_sel                                 : writeback mux select (load type)
//   imm                                    : 6-bit immediate from the instruction
// ----------------------------------------------------------------------------
interface cpu_ctrl_fsm_if #(
   parameter int unsigned PC_W = 8
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [15:0]     imem_rdata;

   logic            dmem_req;
   logic            dmem_we;
   logic            dmem_ack;

   logic [2:0]      alu_op;
   logic            alu_en;
   logic [3:0]      rf_raddr_a;
   logic [3:0]      rf_raddr_b;
   logic [3:0]      rf_waddr;
   logic            rf_we;
   logic [1:0]      wb_sel;
   logic [5:0]      imm;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      output dmem_req, dmem_we,
      input  dmem_ack,
      output alu_op, alu_en, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, wb_sel, imm
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      input  dmem_req, dmem_we,
      output dmem_ack,
      input  alu_op, alu_en, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, wb_sel, imm
   );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// cpu_ctrl_fsm
//   Multi-cycle control unit. Fetches a 16-bit instruction, decodes it and
//   sequences ALU, register file and data memory for one instruction at a
//   time. Owns the PC.
// Ports
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   run      : 1 = keep fetching; 0 = finish current instruction, idle in FETCH
//   bus      : cpu_ctrl_fsm_if.master (imem/dmem handshakes, datapath controls)
//   pc       : current program counter
//   busy     : high in every state except idle FETCH
//   illegal  : one-cycle pulse on an illegal opcode (trap build only)
// Configuration
//   ILLEGAL_TRAP_EN : when defined, illegal opcodes pulse 'illegal' and enter
//                     HALT (left only by rst). When undefined they act as NOP.
// Handshake and strobe outputs are Moore decodes of the state register so a
// zero-wait memory can ack in the same cycle the request is raised.
// ----------------------------------------------------------------------------
module cpu_ctrl_fsm #(
   parameter int unsigned        PC_W     = 8,
   parameter logic [PC_W-1:0]    RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   cpu_ctrl_fsm_if.master        bus,
   output logic [PC_W-1:0]       pc,
   output logic                  busy,
   output logic                  illegal
);

   localparam int unsigned IR_W = 16;

   // Opcode map
   localparam logic [3:0] OP_LOAD     = 4'h7;
   localparam logic [3:0] OP_STOREMEM = 4'h8;
   localparam logic [3:0] OP_STORERF  = 4'h9;
   localparam logic [3:0] OP_JUMP     = 4'hA;
   localparam logic [3:0] OP_NOP      = 4'hF;

   // Load types (IR[7:6] of a LOAD)
   localparam logic [1:0] LT_RF      = 2'b00;
   localparam logic [1:0] LT_MEM     = 2'b01;
   localparam logic [1:0] LT_IMM     = 2'b10;

   // ALU code used for LOAD (pass-through), outside the 0..6 ALU range
   localparam logic [2:0] LOAD_OP    = 3'b111;

   localparam logic [IR_W-1:0] IR_RESET = 16'hF000;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   state_t            state, state_d;
   logic [IR_W-1:0]   ir, ir_d;
   logic [PC_W-1:0]   pc_d;
   logic              req_pend, req_pend_d;

   logic              imem_req_c;
   logic              dmem_req_c;
   logic              dmem_we_c;
   logic              alu_en_c;
   logic              rf_we_c;
   logic              busy_c;
   logic              illegal_c;

   // Instruction field decode
   logic [3:0]        op;
   logic [1:0]        load_type;
   logic              is_alu;
   logic              is_load;
   logic              is_illegal;

   assign op         = ir[15:12];
   assign load_type  = ir[7:6];
   assign is_alu     = (op <= 4'd6);
   assign is_load    = (op == OP_LOAD);
   assign is_illegal = (op >= 4'hB) && (op <= 4'hE);

   // Datapath fields straight from IR; stable from DECODE through WB
   assign bus.rf_raddr_a = ir[7:4];
   assign bus.rf_raddr_b = ir[3:0];
   assign bus.rf_waddr   = ir[11:8];
   assign bus.imm        = ir[5:0];

   // ALU code: ALU ops pass op[2:0]; LOAD uses the pass-through code
   always_comb begin
      bus.alu_op = 3'b000;
      if (is_alu) begin
         bus.alu_op = op[2:0];
      end else if (is_load) begin
         bus.alu_op = LOAD_OP;
      end
   end

   // Writeback select: only LOAD chooses a non-RF source; DEFAULT behaves as RF
   always_comb begin
      bus.wb_sel = LT_RF;
      if (is_load && (load_type != 2'b11)) begin
         bus.wb_sel = load_type;
      end
   end

   // State and architectural registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_FETCH;
         ir       <= IR_RESET;
         pc       <= RESET_PC;
         req_pend <= 1'b0;
      end else begin
         state    <= state_d;
         ir       <= ir_d;
         pc       <= pc_d;
         req_pend <= req_pend_d;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d    = state;
      ir_d       = ir;
      pc_d       = pc;
      req_pend_d = req_pend;
      imem_req_c = 1'b0;
      dmem_req_c = 1'b0;
      dmem_we_c  = 1'b0;
      alu_en_c   = 1'b0;
      rf_we_c    = 1'b0;
      busy_c     = 1'b1;
      illegal_c  = 1'b0;

      unique case (state)
         S_FETCH: begin
            // A request already raised stays up until acked, even if run drops
            imem_req_c = run | req_pend;
            busy_c     = imem_req_c;
            if (imem_req_c) begin
               if (bus.imem_ack) begin
                  ir_d       = bus.imem_rdata;
                  req_pend_d = 1'b0;
                  state_d    = S_DECODE;
               end else begin
                  req_pend_d = 1'b1;
               end
            end else begin
               req_pend_d = 1'b0;
            end
         end

         S_DECODE: begin
            if (is_alu) begin
               state_d = S_EXEC;
            end else begin
               unique case (op)
                  OP_LOAD: begin
                     unique case (load_type)
                        LT_MEM:  state_d = S_MEM;
                        LT_IMM:  state_d = S_WB;
                        default: state_d = S_EXEC;
                     endcase
                  end
                  OP_STOREMEM: state_d = S_MEM;
                  OP_STORERF:  state_d = S_WB;
                  OP_JUMP: begin
                     pc_d    = PC_W'(ir);
                     state_d = S_FETCH;
                  end
                  OP_NOP: begin
                     pc_d    = pc + PC_W'(1);
                     state_d = S_FETCH;
                  end
                  default: begin
`ifdef ILLEGAL_TRAP_EN
                     illegal_c = is_illegal;
                     state_d   = S_HALT;
`else
                     // Illegal opcodes retire as NOP
                     pc_d    = pc + PC_W'(1);
                     state_d = S_FETCH;
`endif
                  end
               endcase
            end
         end

         S_EXEC: begin
            alu_en_c = 1'b1;
            state_d  = S_WB;
         end

         S_MEM: begin
            dmem_req_c = 1'b1;
            dmem_we_c  = (op == OP_STOREMEM);
            if (bus.dmem_ack) begin
               if (op == OP_STOREMEM) begin
                  pc_d    = pc + PC_W'(1);
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end
         end

         S_WB: begin
            rf_we_c = 1'b1;
            pc_d    = pc + PC_W'(1);
            state_d = S_FETCH;
         end

         S_HALT: begin
            // Frozen until reset; busy stays high, no requests
            state_d = S_HALT;
         end

         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // While reset is asserted every strobe, request and status output reads 0
   assign bus.imem_req  = imem_req_c & ~rst;
   assign bus.imem_addr = pc;
   assign bus.dmem_req  = dmem_req_c & ~rst;
   assign bus.dmem_we   = dmem_we_c  & ~rst;
   assign bus.alu_en    = alu_en_c   & ~rst;
   assign bus.rf_we     = rf_we_c    & ~rst;
   assign busy          = busy_c     & ~rst;

`ifdef ILLEGAL_TRAP_EN
   assign illegal       = illegal_c  & ~rst;
`else
   assign illegal       = 1'b0;
   logic unused_illegal;
   assign unused_illegal = illegal_c ^ is_illegal;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// tb_cpu_ctrl_fsm
//   Directed bench for cpu_ctrl_fsm: ALU, LOAD MEM with wait states, LOAD IMM,
//   STOREMEM, JUMP with PC wrap, illegal opcode, run drop and mid-MEM reset.
// ----------------------------------------------------------------------------
module tb_cpu_ctrl_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic [7:0] pc;
   logic       busy;
   logic       illegal;

   int unsigned npass  = 0;
   int unsigned ntotal = 0;

   cpu_ctrl_fsm_if #(.PC_W(8)) bus ();

   cpu_ctrl_fsm #(.PC_W(8), .RESET_PC(8'h00)) dut (
      .clk     (clk),
      .rst     (rst),
      .run     (run),
      .bus     (bus),
      .pc      (pc),
      .busy    (busy),
      .illegal (illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Cross one rising edge, land just after the following falling edge
   task automatic nc();
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst            = 1'b1;
      run            = 1'b1;
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 16'h1321;
      bus.dmem_ack   = 1'b0;
      nc();
      nc();

      // Reset state
      check("rst_pc",       32'(pc), 32'h00);
      check("rst_busy",     32'(busy), 32'd0);
      check("rst_imem_req", 32'(bus.imem_req), 32'd0);
      check("rst_alu_op",   32'(bus.alu_op), 32'd0);
      check("rst_wb_sel",   32'(bus.wb_sel), 32'd0);
      check("rst_rf_we",    32'(bus.rf_we), 32'd0);
      check("rst_illegal",  32'(illegal), 32'd0);

      // ALU SUBTRACT 16'h1321: FETCH, DECODE, EXEC, WB
      rst = 1'b0;
      #1;
      check("alu_fetch_req",  32'(bus.imem_req), 32'd1);
      check("alu_fetch_addr", 32'(bus.imem_addr), 32'h00);
      check("alu_fetch_busy", 32'(busy), 32'd1);
      nc();
      check("alu_dec_alu_en", 32'(bus.alu_en), 32'd0);
      check("alu_dec_ra",     32'(bus.rf_raddr_a), 32'd2);
      check("alu_dec_rb",     32'(bus.rf_raddr_b), 32'd1);
      nc();
      check("alu_exec_en",    32'(bus.alu_en), 32'd1);
      check("alu_exec_op",    32'(bus.alu_op), 32'b001);
      check("alu_exec_rfwe",  32'(bus.rf_we), 32'd0);
      nc();
      check("alu_wb_rfwe",    32'(bus.rf_we), 32'd1);
      check("alu_wb_waddr",   32'(bus.rf_waddr), 32'd3);
      check("alu_wb_sel",     32'(bus.wb_sel), 32'd0);
      check("alu_wb_pc",      32'(pc), 32'h00);
      run = 1'b0;
      nc();
      check("idle_pc",        32'(pc), 32'h01);
      check("idle_imem_req",  32'(bus.imem_req), 32'd0);
      check("idle_busy",      32'(busy), 32'd0);

      // LOAD MEM 16'h7540, dmem_ack after three wait cycles
      run            = 1'b1;
      bus.imem_rdata = 16'h7540;
      #1;
      check("ldm_fetch_addr", 32'(bus.imem_addr), 32'h01);
      nc();
      check("ldm_dec_alu_op", 32'(bus.alu_op), 32'b111);
      nc();
      for (int i = 0; i < 4; i++) begin
         bus.dmem_ack = (i == 3);
         #1;
         check($sformatf("ldm_mem_req%0d", i), 32'(bus.dmem_req), 32'd1);
         check($sformatf("ldm_mem_we%0d", i),  32'(bus.dmem_we), 32'd0);
         nc();
      end
      bus.dmem_ack   = 1'b0;
      bus.imem_rdata = 16'h75AA;
      #1;
      check("ldm_wb_rfwe",    32'(bus.rf_we), 32'd1);
      check("ldm_wb_sel",     32'(bus.wb_sel), 32'b01);
      check("ldm_wb_dmem",    32'(bus.dmem_req), 32'd0);
      nc();

      // LOAD IMM 16'h75AA: FETCH, DECODE, WB
      check("ldi_fetch_addr", 32'(bus.imem_addr), 32'h02);
      nc();
      check("ldi_dec_imm",    32'(bus.imm), 32'h2A);
      nc();
      check("ldi_wb_rfwe",    32'(bus.rf_we), 32'd1);
      check("ldi_wb_sel",     32'(bus.wb_sel), 32'b10);
      check("ldi_wb_alu_en",  32'(bus.alu_en), 32'd0);
      bus.imem_rdata = 16'h8210;
      nc();

      // STOREMEM 16'h8210: FETCH, DECODE, MEM
      check("stm_fetch_addr", 32'(bus.imem_addr), 32'h03);
      nc();
      nc();
      bus.dmem_ack = 1'b1;
      #1;
      check("stm_mem_req",    32'(bus.dmem_req), 32'd1);
      check("stm_mem_we",     32'(bus.dmem_we), 32'd1);
      check("stm_mem_rfwe",   32'(bus.rf_we), 32'd0);
      bus.imem_rdata = 16'hF000;
      nc();
      bus.dmem_ack = 1'b0;
      #1;
      check("stm_next_pc",    32'(pc), 32'h04);
      check("stm_next_req",   32'(bus.imem_req), 32'd1);
      check("stm_next_rfwe",  32'(bus.rf_we), 32'd0);

      // JUMP 16'hA0FF from pc=0, then NOP wraps FF -> 00
      rst = 1'b1;
      nc();
      rst            = 1'b0;
      bus.imem_rdata = 16'hA0FF;
      #1;
      check("jmp_fetch_addr", 32'(bus.imem_addr), 32'h00);
      nc();
      nc();
      check("jmp_target_pc",  32'(pc), 32'hFF);
      check("jmp_imem_addr",  32'(bus.imem_addr), 32'hFF);
      bus.imem_rdata = 16'hF000;
      nc();
      nc();
      check("nop_wrap_pc",    32'(pc), 32'h00);

      // Illegal opcode 16'hB000 at pc=0
      bus.imem_rdata = 16'hB000;
      nc();
`ifdef ILLEGAL_TRAP_EN
      check("ill_dec_pulse",  32'(illegal), 32'd1);
      nc();
      check("ill_halt_pulse", 32'(illegal), 32'd0);
      check("ill_halt_req",   32'(bus.imem_req), 32'd0);
      check("ill_halt_busy",  32'(busy), 32'd1);
      check("ill_halt_pc",    32'(pc), 32'h00);
      nc();
      check("ill_halt_pc2",   32'(pc), 32'h00);
`else
      check("ill_dec_pulse",  32'(illegal), 32'd0);
      nc();
      check("ill_nop_pc",     32'(pc), 32'h01);
      check("ill_nop_illeg",  32'(illegal), 32'd0);
      check("ill_nop_req",    32'(bus.imem_req), 32'd1);
`endif

      // Reset during a LOAD MEM wait
      rst = 1'b1;
      nc();
      rst            = 1'b0;
      bus.imem_rdata = 16'h7540;
      nc();
      nc();
      check("rmem_req",       32'(bus.dmem_req), 32'd1);
      nc();
      check("rmem_wait_req",  32'(bus.dmem_req), 32'd1);
      rst = 1'b1;
      nc();
      rst = 1'b0;
      run = 1'b0;
      #1;
      check("rmem_dmem_req",  32'(bus.dmem_req), 32'd0);
      check("rmem_rf_we",     32'(bus.rf_we), 32'd0);
      check("rmem_pc",        32'(pc), 32'h00);
      check("rmem_busy",      32'(busy), 32'd0);

      // run drops while a fetch request is outstanding: request held to ack
      run          = 1'b1;
      bus.imem_ack = 1'b0;
      #1;
      check("hold_req0",      32'(bus.imem_req), 32'd1);
      nc();
      run = 1'b0;
      #1;
      check("hold_req1",      32'(bus.imem_req), 32'd1);
      check("hold_busy1",     32'(busy), 32'd1);
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 16'hF000;
      nc();
      bus.imem_ack = 1'b0;
      nc();
      check("hold_done_pc",   32'(pc), 32'h01);
      check("hold_done_req",  32'(bus.imem_req), 32'd0);
      check("hold_done_busy", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
